// File: rtl/mw_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : mw_mem_stage
// Purpose : Memory-writeback stage of the 3-stage 16-bit core. Consumes the
//           DE->MW pipeline register fields, runs a req/ack data-memory
//           transaction for loads and stores, stalls upstream while one is
//           pending and produces the register-file writeback.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           mw_*_i               - registered MW control/data fields
//           dmem_*               - data-memory req/ack interface
//           stall_o              - hold IF/DE and DE/MW registers
//           wb_en_o, wb_data_o   - register-file writeback
//           err_o                - one-cycle bus/alignment error pulse
// Revision: 1.0 - initial release
// ============================================================================
module mw_mem_stage #(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mw_pc_i,
    input  logic [1:0]        mw_wb_sel_i,
    input  logic              mw_mem_write_en_i,
    input  logic              mw_mem_read_en_i,
    input  logic [DATA_W-1:0] mw_rd_data_i,
    input  logic [DATA_W-1:0] mw_alu_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic              stall_o,
    output logic              wb_en_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [1:0]       SEL_ALU      = 2'b00;
    localparam logic [1:0]       SEL_MEM      = 2'b01;
    localparam logic [1:0]       SEL_LINK     = 2'b10;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] load_data;
    logic              err_q;

    logic mem_op;
    logic bad_op;
    logic is_load;

    assign mem_op  = mw_mem_read_en_i | mw_mem_write_en_i;
    // Misaligned halfword access, or an instruction claiming both load and store.
    assign bad_op  = (mw_mem_read_en_i & mw_mem_write_en_i) | mw_alu_data_i[0];
    assign is_load = mw_mem_read_en_i & ~mw_mem_write_en_i;

    // ------------------------------------------------------------------
    // Next-state, stall and writeback enable
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        wb_en_o    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall_o    = 1'b1;
                    state_next = bad_op ? ERR : BUSY;
                end else begin
                    // Sel 01 with no load has nothing to write back.
                    wb_en_o = (mw_wb_sel_i == SEL_ALU) || (mw_wb_sel_i == SEL_LINK);
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                // Ack takes priority over a timeout in the same cycle.
                if (dmem_ack_i) begin
                    state_next = RESP;
                end else if (count == TIMEOUT_LAST) begin
                    state_next = ERR;
                end
            end
            RESP: begin
                wb_en_o    = is_load && (mw_wb_sel_i == SEL_MEM);
                state_next = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            stall_o = 1'b0;
            wb_en_o = 1'b0;
        end
    end

    always_comb begin
        case (mw_wb_sel_i)
            SEL_MEM:  wb_data_o = load_data;
            SEL_LINK: wb_data_o = mw_pc_i + DATA_W'(2);
            default:  wb_data_o = mw_alu_data_i;
        endcase
    end

    assign err_o = err_q;

    // ------------------------------------------------------------------
    // State, memory interface registers and timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            load_data    <= '0;
            err_q        <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= (state_next == ERR);
            case (state)
                IDLE: begin
                    if (mem_op && !bad_op) begin
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mw_mem_write_en_i;
                        dmem_addr_o  <= mw_alu_data_i;
                        dmem_wdata_o <= mw_rd_data_i;
                        count        <= '0;
                    end
                end
                BUSY: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        if (!dmem_we_o) begin
                            load_data <= dmem_rdata_i;
                        end
                    end else if (count == TIMEOUT_LAST) begin
                        dmem_req_o <= 1'b0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mw_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mw_mem_stage
// Purpose : Self-checking bench for mw_mem_stage: table of single-cycle
//           writeback vectors plus directed load/store/timeout/error/reset
//           sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mw_mem_stage;

    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] mw_pc_i;
    logic [1:0]        mw_wb_sel_i;
    logic              mw_mem_write_en_i;
    logic              mw_mem_read_en_i;
    logic [DATA_W-1:0] mw_rd_data_i;
    logic [DATA_W-1:0] mw_alu_data_i;
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [DATA_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic [DATA_W-1:0] dmem_rdata_i;
    logic              dmem_ack_i;
    logic              stall_o;
    logic              wb_en_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              err_o;

    int total = 0;
    int bad   = 0;

    mw_mem_stage #(
        .DATA_W        (16),
        .TIMEOUT_CYCLES(15),
        .CNT_W         (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mw_pc_i          (mw_pc_i),
        .mw_wb_sel_i      (mw_wb_sel_i),
        .mw_mem_write_en_i(mw_mem_write_en_i),
        .mw_mem_read_en_i (mw_mem_read_en_i),
        .mw_rd_data_i     (mw_rd_data_i),
        .mw_alu_data_i    (mw_alu_data_i),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_rdata_i     (dmem_rdata_i),
        .dmem_ack_i       (dmem_ack_i),
        .stall_o          (stall_o),
        .wb_en_o          (wb_en_o),
        .wb_data_o        (wb_data_o),
        .err_o            (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [1:0]  sel;
        logic [15:0] alu;
        logic        exp_en;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle for sampling.
    task automatic settle();
        #4;
    endtask

    task automatic set_op(input logic [15:0] pc, input logic [1:0] sel, input logic we,
                          input logic re, input logic [15:0] rd, input logic [15:0] alu);
        mw_pc_i           = pc;
        mw_wb_sel_i       = sel;
        mw_mem_write_en_i = we;
        mw_mem_read_en_i  = re;
        mw_rd_data_i      = rd;
        mw_alu_data_i     = alu;
    endtask

    task automatic set_nop();
        set_op(16'h0000, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        int req_cycles;
        int n;

        vecs[0] = '{16'h0000, 2'b00, 16'h1234, 1'b1, 16'h1234};
        vecs[1] = '{16'h0100, 2'b10, 16'h5555, 1'b1, 16'h0102};
        vecs[2] = '{16'hFFFE, 2'b10, 16'h0000, 1'b1, 16'h0000};
        vecs[3] = '{16'h0000, 2'b00, 16'hFFFF, 1'b1, 16'hFFFF};
        vecs[4] = '{16'h0000, 2'b11, 16'h0042, 1'b0, 16'h0042};
        vecs[5] = '{16'h0000, 2'b01, 16'h0042, 1'b0, 16'h0000};

        rst          = 1'b1;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 16'h0000;
        set_op(16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h1234);

        // Reset: stall/wb forced low, memory outputs cleared.
        tick();
        tick();
        settle();
        chk("rst_stall", stall_o, 0);
        chk("rst_wb_en", wb_en_o, 0);
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_err", err_o, 0);
        tick();
        rst = 1'b0;

        // Table of non-memory writeback vectors, one per IDLE cycle.
        for (int i = 0; i < 6; i++) begin
            set_op(vecs[i].pc, vecs[i].sel, 1'b0, 1'b0, 16'h0000, vecs[i].alu);
            settle();
            chk($sformatf("vec%0d_wb_en", i), wb_en_o, vecs[i].exp_en);
            if (vecs[i].exp_en)
                chk($sformatf("vec%0d_wb_data", i), wb_data_o, vecs[i].exp_data);
            chk($sformatf("vec%0d_stall", i), stall_o, 0);
            chk($sformatf("vec%0d_req", i), dmem_req_o, 0);
            tick();
        end

        // Load at 0x0040, ack on second BUSY cycle with 0xBEEF.
        set_op(16'h0200, 2'b01, 1'b0, 1'b1, 16'h0000, 16'h0040);
        settle();
        chk("ld_c0_stall", stall_o, 1);
        chk("ld_c0_wb_en", wb_en_o, 0);
        chk("ld_c0_req", dmem_req_o, 0);
        tick();
        settle();
        chk("ld_c1_req", dmem_req_o, 1);
        chk("ld_c1_we", dmem_we_o, 0);
        chk("ld_c1_addr", dmem_addr_o, 16'h0040);
        chk("ld_c1_stall", stall_o, 1);
        tick();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'hBEEF;
        settle();
        chk("ld_c2_req", dmem_req_o, 1);
        chk("ld_c2_stall", stall_o, 1);
        tick();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 16'h0000;
        settle();
        chk("ld_c3_req", dmem_req_o, 0);
        chk("ld_c3_stall", stall_o, 0);
        chk("ld_c3_wb_en", wb_en_o, 1);
        chk("ld_c3_wb_data", wb_data_o, 16'hBEEF);
        chk("ld_c3_err", err_o, 0);
        tick();
        set_nop();

        // Store 0xA5A5 to 0x0010, ack in first BUSY cycle.
        set_op(16'h0300, 2'b11, 1'b1, 1'b0, 16'hA5A5, 16'h0010);
        settle();
        chk("st_c0_stall", stall_o, 1);
        chk("st_c0_wb_en", wb_en_o, 0);
        tick();
        dmem_ack_i = 1'b1;
        settle();
        chk("st_c1_req", dmem_req_o, 1);
        chk("st_c1_we", dmem_we_o, 1);
        chk("st_c1_addr", dmem_addr_o, 16'h0010);
        chk("st_c1_wdata", dmem_wdata_o, 16'hA5A5);
        chk("st_c1_stall", stall_o, 1);
        chk("st_c1_wb_en", wb_en_o, 0);
        tick();
        dmem_ack_i = 1'b0;
        settle();
        chk("st_c2_req", dmem_req_o, 0);
        chk("st_c2_stall", stall_o, 0);
        chk("st_c2_wb_en", wb_en_o, 0);
        tick();
        set_nop();

        // Timeout: load at 0x0080, ack never comes.
        set_op(16'h0400, 2'b01, 1'b0, 1'b1, 16'h0000, 16'h0080);
        tick();
        req_cycles = 0;
        n = 0;
        settle();
        while (!err_o && n < 40) begin
            if (dmem_req_o) req_cycles++;
            chk("to_wb_en_busy", wb_en_o, 0);
            tick();
            settle();
            n++;
        end
        chk("to_err_seen", err_o, 1);
        chk("to_req_cycles", req_cycles, 15);
        chk("to_err_stall", stall_o, 0);
        chk("to_err_wb_en", wb_en_o, 0);
        chk("to_err_req", dmem_req_o, 0);
        tick();
        set_nop();
        dmem_ack_i = 1'b1;
        settle();
        chk("to_post_err", err_o, 0);
        chk("to_late_ack_req", dmem_req_o, 0);
        chk("to_late_ack_stall", stall_o, 0);
        tick();
        settle();
        chk("to_late_ack_err", err_o, 0);
        tick();
        dmem_ack_i = 1'b0;

        // Misaligned load at 0x0041.
        set_op(16'h0500, 2'b01, 1'b0, 1'b1, 16'h0000, 16'h0041);
        settle();
        chk("mis_c0_stall", stall_o, 1);
        chk("mis_c0_req", dmem_req_o, 0);
        chk("mis_c0_err", err_o, 0);
        tick();
        settle();
        chk("mis_c1_err", err_o, 1);
        chk("mis_c1_req", dmem_req_o, 0);
        chk("mis_c1_stall", stall_o, 0);
        chk("mis_c1_wb_en", wb_en_o, 0);
        tick();
        set_nop();
        settle();
        chk("mis_c2_err", err_o, 0);
        tick();

        // Read and write both set at an aligned address.
        set_op(16'h0600, 2'b01, 1'b1, 1'b1, 16'h1111, 16'h0040);
        settle();
        chk("rw_c0_stall", stall_o, 1);
        chk("rw_c0_req", dmem_req_o, 0);
        tick();
        settle();
        chk("rw_c1_err", err_o, 1);
        chk("rw_c1_req", dmem_req_o, 0);
        chk("rw_c1_stall", stall_o, 0);
        tick();
        set_nop();

        // Reset while BUSY, then a link op at pc 0xFFFE.
        set_op(16'h0700, 2'b01, 1'b0, 1'b1, 16'h0000, 16'h0020);
        tick();
        settle();
        chk("rb_busy_req", dmem_req_o, 1);
        tick();
        rst = 1'b1;
        settle();
        chk("rb_rst_stall", stall_o, 0);
        chk("rb_rst_wb_en", wb_en_o, 0);
        tick();
        rst = 1'b0;
        set_op(16'hFFFE, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        chk("rb_req", dmem_req_o, 0);
        chk("rb_err", err_o, 0);
        chk("rb_link_wb_en", wb_en_o, 1);
        chk("rb_link_wb_data", wb_data_o, 16'h0000);
        chk("rb_link_stall", stall_o, 0);
        tick();
        settle();
        chk("rb_err_after", err_o, 0);
        chk("rb_req_after", dmem_req_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
